// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit-channel arbiter.
package uart_arb_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } arb_state_e;

    // Round-robin successor of cur among num_req requesters.
    function automatic int unsigned next_rr_ptr(input int unsigned cur, input int unsigned num_req);
        return (cur + 32'd1 >= num_req) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module uart_rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte channel among NUM_REQ producers.
// Optional HOLD stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic                         grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic               last_reg;

    logic [IDX_W-1:0]   winner;
    logic               any_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               take_c;
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Accept path: IDLE arbitrates among all, HOLD only listens to the owner.
    always_comb begin
        sel_idx   = (state == IDLE) ? winner : grant_id;
        take_c    = ((state == IDLE) && any_valid) ||
                    ((state == HOLD) && req_valid[grant_id]);
        req_ready = take_c ? (NUM_REQ'(1) << sel_idx) : '0;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(HOLD_TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            burst_cnt   <= '0;
            last_reg    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE, HOLD: begin
                    if (take_c) begin
                        tx_data  <= req_bytes[sel_idx];
                        last_reg <= req_last[sel_idx];
                        tx_start <= 1'b1;
                        state    <= START;
                        if (state == IDLE) begin
                            grant_id    <= winner;
                            grant_valid <= 1'b1;
                            burst_cnt   <= BURST_W'(1);
                        end else begin
                            burst_cnt   <= burst_cnt + BURST_W'(1);
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (state == HOLD) begin
                        // Owner stalled too long mid-packet: release like a normal end of grant.
                        if (stall_cnt == STALL_W'(HOLD_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            grant_valid <= 1'b0;
                            ptr         <= IDX_W'(next_rr_ptr(32'(grant_id), NUM_REQ));
                            state       <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
`endif
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (!last_reg && (burst_cnt < BURST_W'(MAX_BURST))) begin
                            state <= HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                            stall_cnt <= '0;
`endif
                        end else begin
                            grant_valid <= 1'b0;
                            ptr         <= IDX_W'(next_rr_ptr(32'(grant_id), NUM_REQ));
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, HOLD_TIMEOUT=32).
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  req_valid;
    logic [7:0]  rb [4];
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        tx_done_model, tx_done_man;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        timeout_err;

    assign req_data = {rb[3], rb[2], rb[1], rb[0]};
    assign tx_done  = tx_done_model | tx_done_man;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (8),
        .MAX_BURST    (4),
        .HOLD_TIMEOUT (32)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { int id; logic [7:0] data; logic last; } ent_t;
    typedef struct { logic [7:0] data; logic [1:0] id; } exp_t;

    ent_t pend[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = -10;
    int   n_starts = 0;
    int   bcnt = 0;
    logic busy = 1'b0;
    logic uart_auto = 1'b1;
    logic [7:0] cap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int id, input logic [7:0] data, input logic last);
        ent_t e;
        e.id = id; e.data = data; e.last = last;
        pend.push_back(e);
    endtask

    task automatic expect_tx(input logic [7:0] data, input logic [1:0] id);
        exp_t e;
        e.data = data; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            logic found;
            found = 1'b0;
            req_valid[i] = 1'b0; rb[i] = '0; req_last[i] = 1'b0;
            foreach (pend[k]) begin
                if (!found && pend[k].id == i) begin
                    found = 1'b1;
                    req_valid[i] = 1'b1; rb[i] = pend[k].data; req_last[i] = pend[k].last;
                end
            end
        end
    endtask

    task automatic pop_front(input int id);
        int idx;
        idx = -1;
        foreach (pend[k]) if (idx < 0 && pend[k].id == id) idx = k;
        if (idx >= 0) pend.delete(idx);
    endtask

    // Requester model: retire accepted bytes, then present each producer's next byte.
    always begin : driver
        logic [3:0] acc;
        @(negedge PCLK);
        acc = req_valid & req_ready;
        @(posedge PCLK);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) pop_front(i);
        drive_reqs();
    end

    // uart_tx responder plus scoreboard compare on every tx_start.
    always @(negedge PCLK) begin : monitor
        exp_t e;
        cyc++;
        tx_done_model = 1'b0;
        if (PRESET) begin
            busy = 1'b0;
        end else begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (busy) begin
                check("tx_data_stable", 32'(tx_data), 32'(cap));
                bcnt--;
                if (bcnt == 0) begin
                    tx_done_model = 1'b1;
                    busy = 1'b0;
                end
            end
            if (|(req_valid & req_ready)) acc_cyc = cyc;
            if (tx_start) begin
                n_starts++;
                check("start_while_busy", 32'(busy), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("grant_id_at_start", 32'(grant_id), 32'(e.id));
                    check("accept_to_start_latency", 32'(cyc - acc_cyc), 1);
                end
                if (uart_auto) begin
                    busy = 1'b1;
                    cap  = tx_data;
                    bcnt = 2 + int'($urandom_range(0, 3));
                end
            end
        end
    end

    task automatic step();
        @(negedge PCLK);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (n < 2000 && (exp_q.size() != 0 || busy || pend.size() != 0 || grant_valid)) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(n < 2000), 1);
    endtask

    task automatic wait_grant(input logic [1:0] id);
        int n;
        n = 0;
        while (n < 200 && !(grant_valid && grant_id == id)) begin
            step();
            n++;
        end
        check("wait_grant", 32'(n < 200), 1);
    endtask

    initial begin : main
        int n;
        int s;
        logic seen;
        PRESET = 1'b1;
        req_valid = '0; req_last = '0;
        for (int i = 0; i < 4; i++) rb[i] = '0;
        tx_done_man = 1'b0;
        tx_done_model = 1'b0;
        repeat (3) step();

        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_ptr", 32'(dut.ptr), 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        step();

        // Single byte from requester 0
        expect_tx(8'hA5, 2'd0);
        push(0, 8'hA5, 1'b1);
        wait_drain("t1");
        check("t1_ptr", 32'(dut.ptr), 1);
        check("t1_grant_valid", 32'(grant_valid), 0);

        // All four contend, requester 0 has a second packet
        @(negedge PCLK); PRESET = 1'b1;
        @(negedge PCLK); PRESET = 1'b0;
        expect_tx(8'h10, 2'd0); expect_tx(8'h11, 2'd1);
        expect_tx(8'h12, 2'd2); expect_tx(8'h13, 2'd3);
        expect_tx(8'h14, 2'd0);
        push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
        push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        wait_drain("t2");
        check("t2_ptr", 32'(dut.ptr), 1);

        // Packet lock: requester 2 keeps the channel while requester 1 waits
        expect_tx(8'h01, 2'd2); expect_tx(8'h02, 2'd2); expect_tx(8'h03, 2'd2);
        expect_tx(8'h20, 2'd1);
        push(2, 8'h01, 1'b0); push(2, 8'h02, 1'b0); push(2, 8'h03, 1'b1);
        wait_grant(2'd2);
        push(1, 8'h20, 1'b1);
        wait_drain("t3");
        check("t3_ptr", 32'(dut.ptr), 2);

        // Forced rotation after MAX_BURST=4 bytes
        for (int i = 0; i < 4; i++) expect_tx(8'(8'h30 + i), 2'd0);
        expect_tx(8'h40, 2'd3);
        expect_tx(8'h34, 2'd0); expect_tx(8'h35, 2'd0);
        for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i), i == 5);
        wait_grant(2'd0);
        push(3, 8'h40, 1'b1);
        wait_drain("t4");
        check("t4_ptr", 32'(dut.ptr), 1);

        // Reset while waiting for tx_done, then a stale tx_done
        uart_auto = 1'b0;
        expect_tx(8'h50, 2'd1);
        push(1, 8'h50, 1'b1);
        wait_grant(2'd1);
        repeat (3) step();
        check("t5_state_wait", 32'(dut.state), 32'(WAIT));
        s = n_starts;
        @(posedge PCLK); #2;
        PRESET = 1'b1;
        #1;
        check("t5_tx_start", 32'(tx_start), 0);
        check("t5_grant_valid", 32'(grant_valid), 0);
        check("t5_ptr", 32'(dut.ptr), 0);
        check("t5_req_ready", 32'(req_ready), 0);
        @(negedge PCLK); PRESET = 1'b0;
        @(negedge PCLK); tx_done_man = 1'b1;
        @(negedge PCLK); tx_done_man = 1'b0;
        repeat (8) step();
        check("t5_no_new_start", 32'(n_starts), 32'(s));
        check("t5_state_idle", 32'(dut.state), 32'(IDLE));
        check("t5_grant_valid_after", 32'(grant_valid), 0);
        check("t5_exp_empty", 32'(exp_q.size()), 0);
        uart_auto = 1'b1;

        // Owner stalls mid-packet in HOLD
        expect_tx(8'h60, 2'd1);
        push(1, 8'h60, 1'b0);
        n = 0;
        while (n < 200 && dut.state != HOLD) begin step(); n++; end
        check("t6_reached_hold", 32'(n < 200), 1);
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (n < 100 && !timeout_err) begin step(); n++; end
        check("t6_timeout_cycles", 32'(n), 32);
        check("t6_grant_valid", 32'(grant_valid), 0);
        check("t6_ptr", 32'(dut.ptr), 2);
        step();
        check("t6_timeout_pulse", 32'(timeout_err), 0);
`else
        seen = 1'b0;
        repeat (40) begin step(); seen = seen | timeout_err; end
        check("t6_no_timeout", 32'(seen), 0);
        check("t6_still_hold", 32'(dut.state), 32'(HOLD));
        check("t6_grant_held", 32'(grant_valid), 1);
        expect_tx(8'h61, 2'd1);
        push(1, 8'h61, 1'b1);
        wait_drain("t6");
        check("t6_ptr", 32'(dut.ptr), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte channel (tx_data/tx_start/tx_done of the uart_tx engine) among NUM_REQ independent byte producers.
- Arbitration is round-robin, with packet lock: the grant is held until the requester's last byte or MAX_BURST bytes.
- Sits between the requesters and the uart_tx engine inside the UART peripheral. Strictly one byte is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_BURST, 16, max bytes per grant before forced rotation (>=1)
HOLD_TIMEOUT, 1024, stall cycles in HOLD before forced release (used only with UART_ARB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock
PRESET  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte is the final byte of its packet
req_ready  out  NUM_REQ  one-hot; byte accepted when valid&ready
tx_data  out  DATA_W  byte to uart_tx; held stable from START until tx_done
tx_start  out  1  single-cycle pulse to uart_tx
tx_done  in  1  single-cycle pulse from uart_tx after the stop bit
grant_valid  out  1  a requester currently owns the channel
grant_id  out  $clog2(NUM_REQ)  current owner
timeout_err  out  1  single-cycle pulse on forced release (tied 0 without macro)

Behaviour:
- Reset values: state IDLE, tx_start=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0, rr pointer=0, burst_cnt=0, timeout_err=0.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - Winner = first i with req_valid[i], searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle.
  - On the clock edge: latch data and last, grant_id<=winner, grant_valid<=1, burst_cnt<=1, go START.
  - No valid requester: stay in IDLE.
- START:
  - tx_start=1 for exactly one cycle; go WAIT.
  - Latency: byte accept to tx_start is 1 cycle.
- WAIT:
  - Wait for tx_done.
  - On tx_done, if last_reg==0 and burst_cnt<MAX_BURST: go HOLD.
  - Otherwise release: grant_valid<=0, ptr<=(grant_id+1) mod NUM_REQ, go IDLE.
- HOLD:
  - Only the owner is considered. If req_valid[grant_id]: req_ready[grant_id]=1, latch, burst_cnt+1, go START.
  - Valid inputs from other requesters are ignored.
- req_ready is only ever asserted in IDLE or HOLD, and to at most one requester.
- tx_done outside WAIT is ignored.
- Forced rotation at MAX_BURST also advances ptr. The interrupted requester re-arbitrates normally and continues its packet when next granted.
- ptr wraps from NUM_REQ-1 to 0. burst_cnt width is $clog2(MAX_BURST+1) and never exceeds MAX_BURST.
- PRESET mid-operation: immediately returns to reset values. Any byte in flight in uart_tx is not tracked; a later tx_done is ignored because the state is IDLE.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter counts cycles spent in HOLD with req_valid[grant_id]==0.
  - When it reaches HOLD_TIMEOUT: timeout_err pulses one cycle, grant released as a normal release (ptr advances), go IDLE.
  - The counter clears on every entry to HOLD.
- Undefined: HOLD waits indefinitely, no counter is built, and timeout_err is tied 0.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_e {IDLE, START, WAIT, HOLD}
  - DATA_W default constant
  - function next_rr_ptr
- One sub-module: uart_rr_picker.
  - Combinational. Inputs req_valid and ptr; outputs winner index and any_valid.
  - Reused by future shared-resource arbiters.

Test Plan:
1. Req0 sends 0xA5 with last=1, NUM_REQ=4 -> req_ready[0] pulses 1 cycle, tx_start pulses the next cycle, tx_data=0xA5 stable until tx_done, then IDLE with ptr=1.
2. All four requesters valid with single last=1 bytes 0x10..0x13 -> tx order 0x10, 0x11, 0x12, 0x13, then req0 again; exactly one tx_start per tx_done.
3. Req2 sends packet 0x01, 0x02, 0x03 (last on 0x03) while req1 stays valid -> three bytes go out consecutively with grant_id=2 throughout, then req1.
4. MAX_BURST=4; req0 streams 6 bytes without last, req3 valid -> 4 bytes from req0, then req3, then req0's remaining 2 bytes.
5. PRESET asserted in WAIT, then tx_done pulses after release -> tx_start=0, grant_valid=0, ptr=0, no new tx_start.
6. UART_ARB_TIMEOUT_EN with HOLD_TIMEOUT=32; req1 drops valid mid-packet -> timeout_err pulses after 32 stall cycles, grant_valid=0, ptr=2.
